// File: rtl/gray_decode_arbiter.sv
// gray_decode_arbiter: one bit-serial Gray-to-binary decoder shared by NREQ
// requesters through a round-robin arbiter.
//
// Ports:
//   clk, rst_n   - system clock (rising edge), asynchronous active-low reset
//   req_valid    - per-requester request valid
//   req_gray     - packed Gray words, requester k at [k*WIDTH +: WIDTH]
//   req_ready    - one-hot accept strobe, combinational, only high in IDLE
//   out_valid    - decoded result valid (held until out_ready)
//   out_ready    - consumer accepts result
//   out_binary   - decoded binary word, resolved MSB first, one bit per cycle
//   out_id       - index of the requester owning out_binary
//   busy         - high whenever the FSM is not in IDLE
module gray_decode_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_gray,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_binary,
    output logic [IDW-1:0]          out_id,
    output logic                    busy
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] bin_d;
    logic [IDW-1:0]   id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_up;
    logic             valid_d;
    logic             busy_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    int unsigned      cand;
    logic [WIDTH-1:0] sel_gray;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(last_q) + i) % NREQ;
            if (!grant_found && req_valid[IDW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    // Mux the winning requester's Gray word.
    always_comb begin
        sel_gray = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                sel_gray = req_gray[k*WIDTH +: WIDTH];
            end
        end
    end

    // Accept strobe is only offered while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found) begin
            req_ready = NREQ'(1) << grant_idx;
        end
    end

    // Bit position above the one being resolved this cycle.
    assign cnt_up = cnt_q + CW'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        gray_d  = gray_q;
        bin_d   = out_binary;
        id_d    = out_id;
        last_d  = last_q;
        cnt_d   = cnt_q;
        valid_d = out_valid;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    gray_d            = sel_gray;
                    id_d              = grant_idx;
                    last_d            = grant_idx;
                    bin_d[WIDTH-1]    = sel_gray[WIDTH-1];
                    cnt_d             = CW'(WIDTH - 2);
                    state_d           = S_CONV;
                end
            end
            S_CONV: begin
                bin_d[cnt_q] = out_binary[cnt_up] ^ gray_q[cnt_q];
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gray_q     <= '0;
            out_binary <= '0;
            out_id     <= '0;
            last_q     <= IDW'(NREQ - 1);
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            gray_q     <= gray_d;
            out_binary <= bin_d;
            out_id     <= id_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            out_valid  <= valid_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Testbench for gray_decode_arbiter: directed and random stimulus, a
// predictor that models arbitration/timing and queues expected results, and
// a monitor that checks each presented result against the queue.
module tb_gray_decode_arbiter;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned GW    = NREQ * WIDTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [GW-1:0]     req_gray;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_binary;
    logic [IDW-1:0]    out_id;
    logic              busy;

    gray_decode_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_binary (out_binary),
        .out_id     (out_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] bin;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Binary is the XOR of the Gray word with all its right shifts.
    function automatic logic [WIDTH-1:0] ref_decode(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int s = 1; s < WIDTH; s++) b = b ^ (g >> s);
        return b;
    endfunction

    // First valid requester after 'last', wrapping; -1 if none.
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        int idx;
        for (int o = 1; o <= int'(NREQ); o++) begin
            idx = (last + o) % int'(NREQ);
            if (((v >> idx) & NREQ'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] gray_of(input int k);
        return WIDTH'(req_gray >> (k * int'(WIDTH)));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_gray(input int k, input logic [WIDTH-1:0] g);
        logic [GW-1:0] m;
        m = GW'({WIDTH{1'b1}}) << (k * int'(WIDTH));
        req_gray = (req_gray & ~m) | (GW'(g) << (k * int'(WIDTH)));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || out_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy=%0b expected 0 within 60 cycles", busy);
        end
    endtask

    // Present a request mask for exactly one idle cycle.
    task automatic issue(input logic [NREQ-1:0] v);
        wait_idle();
        req_valid = v;
        @(negedge clk);
        req_valid = '0;
    endtask

    // Predictor: arbitration, latency and busy model; pushes expected results.
    int m_last = int'(NREQ) - 1;
    bit m_idle = 1'b1;
    int m_cnt  = 0;
    int p;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk("rst_ready",  32'(req_ready),  32'(0));
                chk("rst_valid",  32'(out_valid),  32'(0));
                chk("rst_busy",   32'(busy),       32'(0));
                chk("rst_binary", 32'(out_binary), 32'(0));
                chk("rst_id",     32'(out_id),     32'(0));
                sb.delete();
                m_last = int'(NREQ) - 1;
                m_idle = 1'b1;
                m_cnt  = 0;
            end else if (m_idle) begin
                chk("idle_busy",  32'(busy),      32'(0));
                chk("idle_valid", 32'(out_valid), 32'(0));
                p = rr_pick(m_last, req_valid);
                if (p < 0) begin
                    chk("no_grant", 32'(req_ready), 32'(0));
                end else begin
                    chk("grant", 32'(req_ready), 32'(1) << p);
                    sb.push_back('{id: IDW'(p), bin: ref_decode(gray_of(p))});
                    m_last = p;
                    m_idle = 1'b0;
                    m_cnt  = int'(WIDTH);
                end
            end else begin
                chk("busy_ready", 32'(req_ready), 32'(0));
                chk("busy_high",  32'(busy),      32'(1));
                if (m_cnt > 0) m_cnt--;
                if (m_cnt == 0) begin
                    chk("valid_hi", 32'(out_valid), 32'(1));
                    if (out_ready) m_idle = 1'b1;
                end else begin
                    chk("valid_lo", 32'(out_valid), 32'(0));
                end
            end
        end
    end

    // Monitor: compares each presented result with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got id=%0d bin=%0h expected none", out_id, out_binary);
                end else begin
                    chk("out_id",     32'(out_id),     32'(sb[0].id));
                    chk("out_binary", 32'(out_binary), 32'(sb[0].bin));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_gray  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single requests with known codes.
        set_gray(0, 4'b1011); issue(4'b0001);
        set_gray(0, 4'b0110); issue(4'b0001);
        set_gray(0, 4'b1000); issue(4'b0001);

        // Every code through requester 2.
        for (int g = 0; g < 16; g++) begin
            req_gray = GW'($urandom);
            set_gray(2, WIDTH'(g));
            issue(4'b0100);
        end

        // All requesters held valid: strict rotation.
        wait_idle();
        for (int k = 0; k < int'(NREQ); k++) set_gray(k, WIDTH'(3 * k + 5));
        req_valid = 4'b1111;
        repeat (32) @(negedge clk);
        req_valid = '0;

        // Backpressure in DONE with pending requests.
        wait_idle();
        out_ready = 1'b0;
        set_gray(1, 4'b1110);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        req_valid = 4'b1111;
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        req_valid = '0;

        // Skipping past the last grant and sparse requests.
        issue(4'b0001);
        issue(4'b1001);
        issue(4'b0100);

        // Reset during conversion, then rotation restarts at 0.
        wait_idle();
        set_gray(1, 4'b0101);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        req_valid = '0;

        // Random traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            req_valid = NREQ'($urandom);
            req_gray  = GW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end

        req_valid = '0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
